xif_alu_pipe: RTL and testbench
===============================

XIF_ALU_PIPE -- requirements
Module: xif_alu_pipe

Interface
REQ-001 Parameter XLEN, default 32: operand/result width.
REQ-002 Parameter ID_W, default 4: transaction ID width.
REQ-003 Parameter LATENCY, default 2, legal 1..4: execute pipeline stages.
REQ-004 Parameter DEPTH, default 4, legal power of two 2..16: max outstanding transactions (credit limit) and result FIFO depth.
REQ-005 Parameter OPCODE, default 7'h5B: custom opcode decoded.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 issue_valid  in  1  core offers an instruction.
REQ-009 issue_ready  out  1  unit can take an instruction this cycle.
REQ-010 issue_accept  out  1  offered instruction is ours; valid only while issue_valid.
REQ-011 issue_instr  in  32  R-type instruction word.
REQ-012 issue_opa, issue_opb  in  XLEN  rs1/rs2 values.
REQ-013 issue_id  in  ID_W  transaction ID.
REQ-014 result_valid  out  1  result_* holds a result.
REQ-015 result_ready  in  1  core consumes result.
REQ-016 result_id  out  ID_W; result_rd  out  5; result_data  out  XLEN.

Function
REQ-017 issue_accept SHALL be combinational: issue_valid && opcode==OPCODE && funct7==7'h00.
REQ-018 An instruction SHALL be taken only on an edge where issue_valid && issue_ready && issue_accept; otherwise no state changes.
REQ-019 funct3 SHALL select: 0 ADD, 1 SUB, 2 XOR, 3 AND, 4 OR, 5 SLL, 6 SRL, 7 MINU (unsigned min); shifts use opb[$clog2(XLEN)-1:0]; ADD/SUB wrap modulo 2^XLEN.
REQ-020 Taken instruction SHALL carry id, rd (instr[11:7]) and result through exactly LATENCY register stages, then enter the result FIFO.
REQ-021 With FIFO empty, result_valid SHALL rise exactly LATENCY cycles after the taking edge (fall-through when empty).
REQ-022 Results SHALL be returned in issue order; none dropped or duplicated.
REQ-023 result_* SHALL hold stable while result_valid && !result_ready; a result is popped on edge with result_valid && result_ready.
REQ-024 Credit counter (0..DEPTH) SHALL +1 on take, -1 on pop, unchanged when both on same edge.
REQ-025 issue_ready SHALL equal credit < DEPTH; pipeline stages never stall, FIFO can never overflow.
REQ-026 Back-to-back takes each cycle SHALL be sustained while result_ready stays high (throughput 1/cycle).
REQ-027 Rejected offers (issue_accept low) SHALL not consume credit or produce results.

Reset
REQ-028 On reset: result_valid=0, credit=0, all pipe valid bits 0, FIFO empty, issue_ready=1 the following cycle.
REQ-029 Reset mid-operation SHALL discard all in-flight and queued results; no result_valid after reset deasserts until a new take.
REQ-030 Data/id/rd registers need no reset; result_id/rd/data undefined while result_valid=0.

Structure
REQ-031 Package xif_alu_pkg SHALL hold the funct3 op enum, OPCODE default and R-type field position constants.
REQ-032 Result FIFO SHALL be a sub-module xif_result_fifo (parametrised WIDTH, DEPTH, empty fall-through, count output).
REQ-033 ALU SHALL be a combinational function in stage 0; remaining stages are pure delay.

Verification
REQ-034 ADD: instr funct3=0 rd=5, opa=7, opb=0xFFFFFFFF, id=3, result_ready=1 -> result_valid after 2 cycles, data=6, rd=5, id=3.
REQ-035 All ops: opa=0x80000010, opb=0x00000004, funct3 0..7 back-to-back -> 0x80000014, 0x8000000C, 0x80000014, 0x00000000, 0x80000014, 0x00000100, 0x08000001, 0x00000004 in order, one per cycle.
REQ-036 Backpressure: result_ready=0, issue 6 valid instrs each cycle -> exactly 4 taken, issue_ready=0 thereafter; raise result_ready -> ids 0,1,2,3 drain, then 2 remaining taken.
REQ-037 Reject: opcode 0x33 or funct7=0x01 with issue_valid=1 -> issue_accept=0, credit unchanged, no result.
REQ-038 Simultaneous take and pop at credit=4-1 -> credit stays 3, issue_ready stays 1.
REQ-039 Reset with 3 queued, 1 in pipe -> result_valid=0 next cycle and stays 0; issue_ready=1.

Source files
------------

// File: rtl/xif_alu_pkg.sv
// Shared definitions for the custom-opcode ALU unit: op encoding, default
// opcode and R-type field positions.
package xif_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_MINU = 3'd7
  } alu_op_e;

  localparam logic [6:0] OPCODE_DEFAULT = 7'h5B;
  localparam logic [6:0] FUNCT7_BASE    = 7'h00;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

endpackage

// File: rtl/xif_alu_pipe_if.sv
// Issue/result handshake between the core (master) and the ALU unit (slave).
interface xif_alu_pipe_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 4
);
  logic            issue_valid;
  logic            issue_ready;
  logic            issue_accept;
  logic [31:0]     issue_instr;
  logic [XLEN-1:0] issue_opa;
  logic [XLEN-1:0] issue_opb;
  logic [ID_W-1:0] issue_id;
  logic            result_valid;
  logic            result_ready;
  logic [ID_W-1:0] result_id;
  logic [4:0]      result_rd;
  logic [XLEN-1:0] result_data;

  modport master (
    output issue_valid, issue_instr, issue_opa, issue_opb, issue_id, result_ready,
    input  issue_ready, issue_accept, result_valid, result_id, result_rd, result_data
  );

  modport slave (
    input  issue_valid, issue_instr, issue_opa, issue_opb, issue_id, result_ready,
    output issue_ready, issue_accept, result_valid, result_id, result_rd, result_data
  );
endinterface

// File: rtl/xif_result_fifo.sv
// Result FIFO: data written on a push edge is visible at pop_data right after
// that edge when the FIFO was empty; count reports occupancy.
module xif_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             pop_s;

  assign pop_s    = pop && (count_r != {(PTR_W+1){1'b0}});
  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;

  // pointer and occupancy tracking; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/xif_alu_pipe.sv
// Custom-opcode ALU: decodes R-type instructions, computes in stage 0, delays
// through LATENCY stages and returns results in order through a credited FIFO.
module xif_alu_pipe
  import xif_alu_pkg::*;
#(
  parameter int         XLEN    = 32,
  parameter int         ID_W    = 4,
  parameter int         LATENCY = 2,
  parameter int         DEPTH   = 4,
  parameter logic [6:0] OPCODE  = OPCODE_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  xif_alu_pipe_if.slave  xif
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  function automatic logic [XLEN-1:0] alu(input alu_op_e op, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_XOR:  alu = a ^ b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_SLL:  alu = a << sh;
      OP_SRL:  alu = a >> sh;
      OP_MINU: alu = (a < b) ? a : b;
      default: alu = {XLEN{1'b0}};
    endcase
  endfunction

  logic             ours_s;
  logic             take_s;
  logic             pop_s;
  logic [CNT_W-1:0] credit_r;
  logic [LATENCY-1:0] vld_r;
  entry_t           ent_r [LATENCY];
  entry_t           fifo_out_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             unused_s;

  assign ours_s = (xif.issue_instr[OPC_MSB:OPC_LSB] == OPCODE) &&
                  (xif.issue_instr[F7_MSB:F7_LSB] == FUNCT7_BASE);
  assign xif.issue_accept = xif.issue_valid && ours_s;
  assign xif.issue_ready  = credit_r < DEPTH_C;
  assign take_s = xif.issue_valid && xif.issue_ready && xif.issue_accept;
  assign pop_s  = xif.result_valid && xif.result_ready;
  assign unused_s = ^xif.issue_instr[24:15];

  // stage valid shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r <= {LATENCY{1'b0}};
    end else begin
      vld_r[0] <= take_s;
      for (int i = 1; i < LATENCY; i++) vld_r[i] <= vld_r[i-1];
    end
  end

  // stage payload: ALU evaluated once on take, later stages are pure delay
  always_ff @(posedge clk) begin
    if (take_s) begin
      ent_r[0].id   <= xif.issue_id;
      ent_r[0].rd   <= xif.issue_instr[RD_MSB:RD_LSB];
      ent_r[0].data <= alu(alu_op_e'(xif.issue_instr[F3_MSB:F3_LSB]), xif.issue_opa, xif.issue_opb);
    end
    for (int i = 1; i < LATENCY; i++) ent_r[i] <= ent_r[i-1];
  end

  // credits cover pipe plus FIFO, so the FIFO can never overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_r <= {CNT_W{1'b0}};
    end else begin
      case ({take_s, pop_s})
        2'b10:   credit_r <= credit_r + 1'b1;
        2'b01:   credit_r <= credit_r - 1'b1;
        default: credit_r <= credit_r;
      endcase
    end
  end

  xif_result_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_r[LATENCY-1]),
    .push_data (ent_r[LATENCY-1]),
    .pop       (pop_s),
    .pop_data  (fifo_out_s),
    .count     (fifo_count_s)
  );

  assign xif.result_valid = (fifo_count_s != {CNT_W{1'b0}});
  assign xif.result_id    = fifo_out_s.id;
  assign xif.result_rd    = fifo_out_s.rd;
  assign xif.result_data  = fifo_out_s.data;

endmodule

// File: tb/tb_xif_alu_pipe.sv
// Scoreboard bench for xif_alu_pipe: a negedge monitor models credit and
// acceptance and checks every result against a queue filled at take time.
module tb_xif_alu_pipe;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   credit_m;
  int   idx;
  logic acc_m;
  logic take_m;
  logic pop_m;
  exp_t exp_q[$];
  exp_t e;
  logic [31:0] exp_tab [8];

  xif_alu_pipe_if #(.XLEN(32), .ID_W(4)) xif ();

  xif_alu_pipe #(.XLEN(32), .ID_W(4), .LATENCY(2), .DEPTH(DEPTH), .OPCODE(7'h5B)) dut (
    .clk   (clk),
    .reset (reset),
    .xif   (xif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] alu_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a ^ b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return (a < b) ? a : b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] id);
    xif.issue_valid = 1'b1;
    xif.issue_instr = instr;
    xif.issue_opa   = a;
    xif.issue_opb   = b;
    xif.issue_id    = id;
  endtask

  task automatic idle();
    xif.issue_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check_value(tag, exp_q.size(), 0);
  endtask

  // reference model and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      credit_m = 0;
    end else begin
      acc_m = xif.issue_valid && (xif.issue_instr[6:0] == 7'h5B) && (xif.issue_instr[31:25] == 7'h00);
      check_value("accept", xif.issue_accept, acc_m);
      check_value("ready", xif.issue_ready, credit_m < DEPTH);
      take_m = acc_m && (credit_m < DEPTH);
      pop_m  = xif.result_valid && xif.result_ready;
      if (xif.result_valid) begin
        if (exp_q.size() == 0) begin
          check_value("spurious_valid", xif.result_valid, 1'b0);
        end else begin
          check_value("res_data", xif.result_data, exp_q[0].data);
          check_value("res_rd", xif.result_rd, exp_q[0].rd);
          check_value("res_id", xif.result_id, exp_q[0].id);
          if (pop_m) void'(exp_q.pop_front());
        end
      end
      if (take_m) begin
        e.id   = xif.issue_id;
        e.rd   = xif.issue_instr[11:7];
        e.data = alu_m(xif.issue_instr[14:12], xif.issue_opa, xif.issue_opb);
        exp_q.push_back(e);
      end
      credit_m = credit_m + (take_m ? 1 : 0) - (pop_m ? 1 : 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    credit_m = 0;
    exp_tab = '{32'h80000014, 32'h8000000C, 32'h80000014, 32'h00000000,
                32'h80000014, 32'h00000100, 32'h08000001, 32'h00000004};
    reset = 1'b1;
    xif.issue_valid  = 1'b0;
    xif.issue_instr  = 32'h0;
    xif.issue_opa    = 32'h0;
    xif.issue_opb    = 32'h0;
    xif.issue_id     = 4'h0;
    xif.result_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_value("rst_valid", xif.result_valid, 1'b0);
    check_value("rst_ready", xif.issue_ready, 1'b1);
    tick();

    // latency: ADD wraps, result two edges after take
    offer(mk_instr(7'h00, 3'd0, 5'd5, 7'h5B), 32'd7, 32'hFFFFFFFF, 4'd3);
    tick();
    idle();
    @(negedge clk);
    check_value("lat_0", xif.result_valid, 1'b0);
    tick();
    @(negedge clk);
    check_value("lat_1", xif.result_valid, 1'b0);
    tick();
    @(negedge clk);
    check_value("lat_2", xif.result_valid, 1'b1);
    check_value("lat_data", xif.result_data, 32'd6);
    check_value("lat_rd", xif.result_rd, 5'd5);
    check_value("lat_id", xif.result_id, 4'd3);
    repeat (3) tick();

    // all ops back-to-back, one result per cycle
    for (int c = 0; c < 11; c++) begin
      if (c < 8) offer(mk_instr(7'h00, c[2:0], c[4:0] + 5'd1, 7'h5B), 32'h80000010, 32'h00000004, c[3:0]);
      else idle();
      @(negedge clk);
      if (c >= 3) begin
        check_value("thru_valid", xif.result_valid, 1'b1);
        check_value("thru_data", xif.result_data, exp_tab[c-3]);
      end
      tick();
    end
    drain("thru_drain");

    // backpressure: credit limit stops issue at DEPTH
    xif.result_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      offer(mk_instr(7'h00, 3'd0, 5'(idx), 7'h5B), 32'(idx), 32'd100, 4'(idx));
      @(negedge clk);
      if (xif.issue_ready) idx++;
      tick();
    end
    check_value("bp_taken", idx, 4);
    @(negedge clk);
    check_value("bp_ready_low", xif.issue_ready, 1'b0);
    tick();
    xif.result_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      offer(mk_instr(7'h00, 3'd0, 5'(idx), 7'h5B), 32'(idx), 32'd100, 4'(idx));
      @(negedge clk);
      if (xif.issue_ready) idx++;
      tick();
    end
    idle();
    check_value("bp_all_taken", idx, 6);
    drain("bp_drain");

    // rejected offers
    offer(mk_instr(7'h00, 3'd0, 5'd1, 7'h33), 32'd1, 32'd2, 4'd1);
    @(negedge clk);
    check_value("rej_opc", xif.issue_accept, 1'b0);
    tick();
    offer(mk_instr(7'h01, 3'd0, 5'd1, 7'h5B), 32'd1, 32'd2, 4'd2);
    @(negedge clk);
    check_value("rej_f7", xif.issue_accept, 1'b0);
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_value("rej_noresult", xif.result_valid, 1'b0);
      tick();
    end

    // simultaneous take and pop at credit DEPTH-1
    xif.result_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      offer(mk_instr(7'h00, 3'd2, 5'd9, 7'h5B), 32'(c + 8), 32'h55, 4'(c + 8));
      tick();
    end
    idle();
    repeat (4) tick();
    xif.result_ready = 1'b1;
    offer(mk_instr(7'h00, 3'd4, 5'd10, 7'h5B), 32'hA0, 32'h0B, 4'd11);
    @(negedge clk);
    check_value("sim_ready_before", xif.issue_ready, 1'b1);
    check_value("sim_rv", xif.result_valid, 1'b1);
    tick();
    idle();
    xif.result_ready = 1'b0;
    @(negedge clk);
    check_value("sim_ready_after", xif.issue_ready, 1'b1);
    tick();
    xif.result_ready = 1'b1;
    drain("sim_drain");

    // reset with three queued and one in the pipe
    xif.result_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      offer(mk_instr(7'h00, 3'd1, 5'd3, 7'h5B), 32'd50, 32'(c), 4'(c + 12));
      tick();
    end
    idle();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_value("rst_mid_valid", xif.result_valid, 1'b0);
      check_value("rst_mid_ready", xif.issue_ready, 1'b1);
      tick();
    end
    xif.result_ready = 1'b1;
    offer(mk_instr(7'h00, 3'd7, 5'd31, 7'h5B), 32'd9, 32'd4, 4'd7);
    tick();
    idle();
    drain("rst_recover_drain");

    // random mix of ops, rejects and backpressure
    for (int c = 0; c < 80; c++) begin
      xif.result_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        offer(mk_instr(($urandom_range(0, 7) == 0) ? 7'h01 : 7'h00, 3'($urandom_range(0, 7)),
                       5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0) ? 7'h33 : 7'h5B),
              $urandom, $urandom, 4'($urandom_range(0, 15)));
      else
        idle();
      tick();
    end
    idle();
    xif.result_ready = 1'b1;
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
